inbuf_vc_fifo: RTL

INBUF_VC_FIFO -- requirements
Module: inbuf_vc_fifo

---
 rtl/router_pkg.sv | 16 +
 rtl/vc_fifo.sv | 53 +++++
 rtl/inbuf_vc_fifo.sv | 76 +++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router defaults and the VC identifier type used across input-buffer blocks.
package router_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int NUM_VC_DEF = 2;
  localparam int DEPTH_DEF  = 4;

  // Width of a VC index; a single VC still needs a 1-bit select.
  function automatic int vc_width(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

  localparam int VC_W_DEF = vc_width(NUM_VC_DEF);
  typedef logic [VC_W_DEF-1:0] vc_id_t;
endpackage

// File: rtl/vc_fifo.sv
// Single-VC flit FIFO: push/pop at the clock edge, registered occupancy, head visible the cycle after write.
// Push is ignored when full and pop is ignored when empty; the head reads as zero while empty.
module vc_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Storage is never cleared; the empty mask hides stale entries after reset.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/inbuf_vc_fifo.sv
// Router input buffer: one FIFO per VC, link writes into ext_vc, forward side pops int_vc.
// ri is ~full[ext_vc] combinationally; illegal VC indices or popping an empty VC set the sticky err.
module inbuf_vc_fifo
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int VC_W  = vc_width(NUM_VC),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     si,
  output logic                     ri,
  input  logic [DATA_W-1:0]        di,
  input  logic [VC_W-1:0]          ext_vc,
  input  logic [VC_W-1:0]          int_vc,
  input  logic                     deq,
  output logic [NUM_VC-1:0]        full,
  output logic [NUM_VC-1:0]        empty,
  output logic [NUM_VC*CNT_W-1:0]  count,
  output logic [NUM_VC*DATA_W-1:0] q,
  output logic                     err
);
  localparam logic [VC_W:0] NUM_VC_L = (VC_W + 1)'(NUM_VC);

  logic              ext_ok;
  logic              int_ok;
  logic              ext_full;
  logic              int_empty;
  logic              proto_err;
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;

  assign ext_ok = ({1'b0, ext_vc} < NUM_VC_L);
  assign int_ok = ({1'b0, int_vc} < NUM_VC_L);

  // Out-of-range selects fall through to "full"/"empty", which blocks both ports.
  always_comb begin
    ext_full  = 1'b1;
    int_empty = 1'b1;
    for (int v = 0; v < NUM_VC; v++) begin
      if (ext_vc == VC_W'(v)) ext_full  = full[v];
      if (int_vc == VC_W'(v)) int_empty = empty[v];
    end
  end

  assign ri        = ext_ok & ~ext_full;
  assign proto_err = ~ext_ok | ~int_ok | (deq & int_empty);

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push[v] = si & ri & (ext_vc == VC_W'(v));
    assign pop[v]  = deq & int_ok & ~empty[v] & (int_vc == VC_W'(v));

    vc_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[v]),
      .pop   (pop[v]),
      .din   (di),
      .head  (q[v*DATA_W +: DATA_W]),
      .full  (full[v]),
      .empty (empty[v]),
      .count (count[v*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)          err <= 1'b0;
    else if (proto_err) err <= 1'b1;
  end
endmodule
